// File: rtl/alu_rv32m_iter_if.sv
// rtl/alu_rv32m_iter_if.sv - request/response handshake bundle for alu_rv32m_iter
//
// Purpose: groups the operand request channel (valid_in/ready_in/a/b/sel/m)
// and the result channel (valid_out/ready_out/Y/zero) of the iterative ALU.
// Ports:
//   valid_in, a, b, sel, m, ready_out : driven by the requester (master)
//   ready_in, Y, zero, valid_out      : driven by the ALU (slave)
interface alu_rv32m_iter_if #(
    parameter int XLEN = 32
);
    logic            valid_in;
    logic            ready_in;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      sel;
    logic            m;
    logic [XLEN-1:0] Y;
    logic            zero;
    logic            valid_out;
    logic            ready_out;

    modport master (
        output valid_in, a, b, sel, m, ready_out,
        input  ready_in, Y, zero, valid_out
    );

    modport slave (
        input  valid_in, a, b, sel, m, ready_out,
        output ready_in, Y, zero, valid_out
    );
endinterface

// File: rtl/alu_rv32m_iter.sv
// rtl/alu_rv32m_iter.sv - handshaked RV32I ALU with iterative RV32M multiply/divide
//
// Purpose: base integer ops complete with a registered 1-cycle result; M-extension
// ops run on a shared shift-add / restoring-divide datapath for XLEN cycles.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (aborts any operation in flight)
//   bus  : slave side of alu_rv32m_iter_if (request, result, handshakes)
module alu_rv32m_iter #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst,
    alu_rv32m_iter_if.slave bus
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};
    localparam logic [SHW-1:0]  LAST    = SHW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [SHW-1:0]    r_cnt;
    logic [XLEN-1:0]   r_y;
    logic              r_zero;
    logic [2*XLEN-1:0] r_acc;   // mul: {partial high, remaining multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]   r_opd;   // multiplicand or divisor magnitude
    logic [2:0]        r_op;
    logic              r_neg;   // negate the selected result in the final cycle

    logic              w_accept;
    logic              w_last;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_sa;
    logic              w_sb;
    logic              w_neg;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_y;
    logic [XLEN-1:0]   w_base_y;
    logic [XLEN-1:0]   w_sra;
    logic [XLEN-1:0]   w_imm_y;
    logic [SHW-1:0]    w_shamt;
    logic [XLEN:0]     w_msum;
    logic [XLEN:0]     w_dshift;
    logic [XLEN:0]     w_ddiff;
    logic [2*XLEN-1:0] w_mul_next;
    logic [2*XLEN-1:0] w_div_next;
    logic [2*XLEN-1:0] w_step;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_div_val;
    logic [XLEN-1:0]   w_final;

    assign w_accept = bus.valid_in && bus.ready_in;
    assign w_last   = (r_cnt == LAST);

    // Operand signedness by funct3: MULH/MULHSU/DIV/REM treat rs1 as signed,
    // MULH/DIV/REM treat rs2 as signed.
    assign w_a_signed = (bus.sel[2:0] == 3'b001) || (bus.sel[2:0] == 3'b010) ||
                        (bus.sel[2:0] == 3'b100) || (bus.sel[2:0] == 3'b110);
    assign w_b_signed = (bus.sel[2:0] == 3'b001) || (bus.sel[2:0] == 3'b100) ||
                        (bus.sel[2:0] == 3'b110);
    assign w_sa    = w_a_signed && bus.a[XLEN-1];
    assign w_sb    = w_b_signed && bus.b[XLEN-1];
    assign w_mag_a = w_sa ? -bus.a : bus.a;
    assign w_mag_b = w_sb ? -bus.b : bus.b;
    // Remainder follows the dividend's sign; quotient and products the xor.
    assign w_neg   = (bus.sel[2] && bus.sel[1]) ? w_sa : (w_sa ^ w_sb);

    assign w_div0    = bus.sel[2] && (bus.b == '0);
    assign w_ovf     = bus.sel[2] && !bus.sel[0] && (bus.a == MIN_VAL) && (bus.b == ONES);
    assign w_special = bus.m && (w_div0 || w_ovf);

    always_comb begin
        w_special_y = '0;
        if (w_div0) begin
            w_special_y = bus.sel[1] ? bus.a : ONES;
        end else begin
            w_special_y = bus.sel[1] ? '0 : bus.a;
        end
    end

    assign w_shamt = bus.b[SHW-1:0];
    // Kept separate so the arithmetic shift is not dragged unsigned by a mux.
    assign w_sra   = $signed(bus.a) >>> w_shamt;

    always_comb begin
        w_base_y = '0;
        case (bus.sel[3:1])
            3'b000:  w_base_y = bus.sel[0] ? (bus.a - bus.b) : (bus.a + bus.b);
            3'b001:  w_base_y = bus.a << w_shamt;
            3'b010:  w_base_y = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            3'b011:  w_base_y = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
            3'b100:  w_base_y = bus.a ^ bus.b;
            3'b101:  w_base_y = bus.sel[0] ? w_sra : (bus.a >> w_shamt);
            3'b110:  w_base_y = bus.a | bus.b;
            default: w_base_y = bus.a & bus.b;
        endcase
    end

    assign w_imm_y = bus.m ? w_special_y : w_base_y;

    // Shift-add: add the multiplicand into the high half when the multiplier
    // LSB is set, then shift the whole accumulator right by one.
    assign w_msum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opd} : '0);
    assign w_mul_next = {w_msum, r_acc[XLEN-1:1]};

    // Restoring divide: shift the next dividend bit into the remainder and
    // keep the subtraction only if it did not borrow.
    assign w_dshift   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_ddiff    = w_dshift - {1'b0, r_opd};
    assign w_div_next = w_ddiff[XLEN] ? {w_dshift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                      : {w_ddiff[XLEN-1:0],  r_acc[XLEN-2:0], 1'b1};

    assign w_step    = r_op[2] ? w_div_next : w_mul_next;
    assign w_prod    = r_neg ? -w_step : w_step;
    assign w_div_val = r_op[1] ? w_step[2*XLEN-1:XLEN] : w_step[XLEN-1:0];

    always_comb begin
        w_final = '0;
        if (r_op[2]) begin
            w_final = r_neg ? -w_div_val : w_div_val;
        end else if (r_op[1:0] == 2'b00) begin
            w_final = w_prod[XLEN-1:0];
        end else begin
            w_final = w_prod[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = (bus.m && !w_special) ? S_CALC : S_DONE;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.ready_out) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_y    <= '0;
            r_zero <= 1'b0;
            r_acc  <= '0;
            r_opd  <= '0;
            r_op   <= '0;
            r_neg  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt <= '0;
                        r_op  <= bus.sel[2:0];
                        r_neg <= w_neg;
                        if (bus.m && !w_special) begin
                            if (bus.sel[2]) begin
                                r_acc <= {{XLEN{1'b0}}, w_mag_a};
                                r_opd <= w_mag_b;
                            end else begin
                                r_acc <= {{XLEN{1'b0}}, w_mag_b};
                                r_opd <= w_mag_a;
                            end
                        end else begin
                            r_y    <= w_imm_y;
                            r_zero <= (w_imm_y == '0);
                        end
                    end
                end
                S_CALC: begin
                    r_acc <= w_step;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_y    <= w_final;
                        r_zero <= (w_final == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.Y         = r_y;
    assign bus.zero      = r_zero;
    assign bus.valid_out = (r_state == S_DONE);
    assign bus.ready_in  = (r_state == S_IDLE) && !rst;
endmodule

// File: tb/tb_alu_rv32m_iter.sv
// tb/tb_alu_rv32m_iter.sv - self-checking bench for alu_rv32m_iter at XLEN=32 and XLEN=8
module tb_alu_rv32m_iter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [63:0] s_a;
    logic [63:0] s_b;
    logic [3:0]  s_sel;
    logic        s_m;
    logic        s_vin;
    logic        s_rout;
    int          cur_w;

    int n_pass  = 0;
    int n_total = 0;

    alu_rv32m_iter_if #(.XLEN(32)) if32 ();
    alu_rv32m_iter_if #(.XLEN(8))  if8 ();

    alu_rv32m_iter #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
    alu_rv32m_iter #(.XLEN(8))  dut8  (.clk(clk), .rst(rst), .bus(if8.slave));

    assign if32.valid_in  = s_vin && (cur_w == 32);
    assign if32.a         = s_a[31:0];
    assign if32.b         = s_b[31:0];
    assign if32.sel       = s_sel;
    assign if32.m         = s_m;
    assign if32.ready_out = s_rout;
    assign if8.valid_in   = s_vin && (cur_w == 8);
    assign if8.a          = s_a[7:0];
    assign if8.b          = s_b[7:0];
    assign if8.sel        = s_sel;
    assign if8.m          = s_m;
    assign if8.ready_out  = s_rout;

    logic [63:0] o_y;
    logic        o_zero;
    logic        o_vout;
    logic        o_rin;
    always_comb begin
        if (cur_w == 32) begin
            o_y    = {32'b0, if32.Y};
            o_zero = if32.zero;
            o_vout = if32.valid_out;
            o_rin  = if32.ready_in;
        end else begin
            o_y    = {56'b0, if8.Y};
            o_zero = if8.zero;
            o_vout = if8.valid_out;
            o_rin  = if8.ready_in;
        end
    end

    function automatic logic [63:0] mask_of(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    // Reference: RISC-V semantics evaluated with wide plain arithmetic, then truncated.
    function automatic logic [63:0] ref_alu(input int w, input logic [63:0] a, input logic [63:0] b,
                                            input logic [3:0] sel, input logic m);
        logic [63:0]        msk;
        logic [63:0]        ua;
        logic [63:0]        ub;
        logic [63:0]        tmp;
        logic [63:0]        mn;
        longint             sa;
        longint             sb;
        int                 sh;
        logic signed [127:0] pa;
        logic signed [127:0] pb;
        logic signed [127:0] p;
        logic [63:0]        r;
        msk = mask_of(w);
        mn  = 64'd1 << (w - 1);
        ua  = a & msk;
        ub  = b & msk;
        tmp = ua << (64 - w);
        sa  = $signed(tmp) >>> (64 - w);
        tmp = ub << (64 - w);
        sb  = $signed(tmp) >>> (64 - w);
        sh  = int'(ub & 64'(w - 1));
        r   = 64'd0;
        if (!m) begin
            case (sel[3:1])
                3'd0: r = sel[0] ? ua - ub : ua + ub;
                3'd1: r = ua << sh;
                3'd2: r = (sa < sb) ? 64'd1 : 64'd0;
                3'd3: r = (ua < ub) ? 64'd1 : 64'd0;
                3'd4: r = ua ^ ub;
                3'd5: r = sel[0] ? 64'(sa >>> sh) : (ua >> sh);
                3'd6: r = ua | ub;
                default: r = ua & ub;
            endcase
        end else begin
            case (sel[2:0])
                3'd0: r = ua * ub;
                3'd1, 3'd2, 3'd3: begin
                    pa = (sel[1:0] == 2'd3) ? $signed({64'd0, ua}) : 128'(sa);
                    pb = (sel[1:0] == 2'd1) ? 128'(sb) : $signed({64'd0, ub});
                    p  = pa * pb;
                    r  = p[w +: 64];
                end
                3'd4: r = (ub == 0) ? msk : ((ua == mn && ub == msk) ? ua : 64'(sa / sb));
                3'd5: r = (ub == 0) ? msk : ua / ub;
                3'd6: r = (ub == 0) ? ua : ((ua == mn && ub == msk) ? 64'd0 : 64'(sa % sb));
                default: r = (ub == 0) ? ua : ua % ub;
            endcase
        end
        return r & msk;
    endfunction

    function automatic int ref_lat(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic [3:0] sel, input logic m);
        logic [63:0] msk;
        logic        special;
        msk = mask_of(w);
        special = sel[2] && (((b & msk) == 0) ||
                  (!sel[0] && (a & msk) == (64'd1 << (w - 1)) && (b & msk) == msk));
        return (m && !special) ? w : 0;
    endfunction

    function automatic logic [63:0] pick(input int w);
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'd1;
            2: return mask_of(w);
            3: return 64'd1 << (w - 1);
            default: return {$urandom, $urandom} & mask_of(w);
        endcase
    endfunction

    // Drives one request, waits (bounded) for the result, then consumes it.
    task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic [3:0] sel,
                         input logic m, output logic rin_ok, output int lat,
                         output logic [63:0] y, output logic z, output logic rel_ok);
        @(negedge clk);
        s_a = a; s_b = b; s_sel = sel; s_m = m; s_vin = 1'b1;
        rin_ok = o_rin;
        @(posedge clk);
        #1;
        s_vin = 1'b0;
        s_a = {$urandom, $urandom};
        s_b = {$urandom, $urandom};
        s_sel = 4'($urandom);
        s_m = 1'($urandom);
        lat = 0;
        @(negedge clk);
        while (!o_vout && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        y = o_y;
        z = o_zero;
        s_rout = 1'b1;
        @(posedge clk);
        #1;
        s_rout = 1'b0;
        @(negedge clk);
        rel_ok = !o_vout && o_rin;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++; if (if32.Y !== 32'd0) $display("FAIL reset_y32: got %h want 0", if32.Y); else n_pass++;
        n_total++; if (if32.valid_out !== 1'b0) $display("FAIL reset_vout32: got %b want 0", if32.valid_out); else n_pass++;
        n_total++; if (if32.ready_in !== 1'b0) $display("FAIL reset_rin32: got %b want 0", if32.ready_in); else n_pass++;
        n_total++; if (if32.zero !== 1'b0) $display("FAIL reset_zero32: got %b want 0", if32.zero); else n_pass++;
        n_total++; if (if8.Y !== 8'd0) $display("FAIL reset_y8: got %h want 0", if8.Y); else n_pass++;
        n_total++; if (if8.valid_out !== 1'b0) $display("FAIL reset_vout8: got %b want 0", if8.valid_out); else n_pass++;
        n_total++; if (if8.ready_in !== 1'b0) $display("FAIL reset_rin8: got %b want 0", if8.ready_in); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++; if (if32.ready_in !== 1'b1) $display("FAIL release_rin32: got %b want 1", if32.ready_in); else n_pass++;
    endtask

    task automatic test_directed(input int w);
        logic [63:0] msk;
        logic [63:0] mn;
        logic [63:0] ta [12];
        logic [63:0] tb [12];
        logic [3:0]  ts [12];
        logic        tm [12];
        logic        rin_ok;
        logic        rel_ok;
        logic        z;
        logic [63:0] y;
        logic [63:0] ey;
        int          lat;
        int          elat;
        cur_w = w;
        msk = mask_of(w);
        mn  = 64'd1 << (w - 1);
        ta[0]  = 5;            tb[0]  = 7;   ts[0]  = 4'b0000; tm[0]  = 0;
        ta[1]  = 3;            tb[1]  = 3;   ts[1]  = 4'b0001; tm[1]  = 0;
        ta[2]  = mn;           tb[2]  = 4;   ts[2]  = 4'b1011; tm[2]  = 0;
        ta[3]  = 1;            tb[3]  = msk; ts[3]  = 4'b0110; tm[3]  = 0;
        ta[4]  = msk;          tb[4]  = 2;   ts[4]  = 4'b0001; tm[4]  = 1;
        ta[5]  = msk;          tb[5]  = 2;   ts[5]  = 4'b0011; tm[5]  = 1;
        ta[6]  = 7;            tb[6]  = 0;   ts[6]  = 4'b0100; tm[6]  = 1;
        ta[7]  = mn;           tb[7]  = msk; ts[7]  = 4'b0110; tm[7]  = 1;
        ta[8]  = (-64'd7)&msk; tb[8]  = 2;   ts[8]  = 4'b0100; tm[8]  = 1;
        ta[9]  = (-64'd7)&msk; tb[9]  = 2;   ts[9]  = 4'b1110; tm[9]  = 1;
        ta[10] = 7;            tb[10] = 0;   ts[10] = 4'b0111; tm[10] = 1;
        ta[11] = 100 & msk;    tb[11] = 7;   ts[11] = 4'b0101; tm[11] = 1;
        for (int i = 0; i < 12; i++) begin
            ey   = ref_alu(w, ta[i], tb[i], ts[i], tm[i]);
            elat = ref_lat(w, ta[i], tb[i], ts[i], tm[i]);
            do_op(ta[i], tb[i], ts[i], tm[i], rin_ok, lat, y, z, rel_ok);
            n_total++; if (rin_ok !== 1'b1) $display("FAIL dir%0d_w%0d ready_in: got %b want 1", i, w, rin_ok); else n_pass++;
            n_total++; if (lat != elat) $display("FAIL dir%0d_w%0d latency: got %0d want %0d", i, w, lat, elat); else n_pass++;
            n_total++; if (y !== ey) $display("FAIL dir%0d_w%0d Y: got %h want %h", i, w, y, ey); else n_pass++;
            n_total++; if (z !== (ey == 0)) $display("FAIL dir%0d_w%0d zero: got %b want %b", i, w, z, ey == 0); else n_pass++;
            n_total++; if (rel_ok !== 1'b1) $display("FAIL dir%0d_w%0d release: got %b want 1", i, w, rel_ok); else n_pass++;
        end
    endtask

    task automatic test_random(input int w, input int n);
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  sel;
        logic        m;
        logic        rin_ok;
        logic        rel_ok;
        logic        z;
        logic [63:0] y;
        logic [63:0] ey;
        int          lat;
        int          elat;
        cur_w = w;
        for (int i = 0; i < n; i++) begin
            a = pick(w); b = pick(w); sel = 4'($urandom); m = 1'($urandom);
            ey   = ref_alu(w, a, b, sel, m);
            elat = ref_lat(w, a, b, sel, m);
            do_op(a, b, sel, m, rin_ok, lat, y, z, rel_ok);
            n_total++;
            if (y !== ey || z !== (ey == 0) || lat != elat || !rin_ok || !rel_ok)
                $display("FAIL rnd_w%0d m=%b sel=%h a=%h b=%h: got Y=%h z=%b lat=%0d rin=%b rel=%b want Y=%h z=%b lat=%0d",
                         w, m, sel, a, b, y, z, lat, rin_ok, rel_ok, ey, ey == 0, elat);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure(input int w);
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] ey;
        int          lat;
        cur_w = w;
        a = pick(w); b = pick(w);
        ey = ref_alu(w, a, b, 4'b0000, 1'b1);
        @(negedge clk);
        s_a = a; s_b = b; s_sel = 4'b0000; s_m = 1'b1; s_vin = 1'b1;
        @(posedge clk);
        #1 s_vin = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!o_vout && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        n_total++; if (lat != w) $display("FAIL bp_w%0d latency: got %0d want %0d", w, lat, w); else n_pass++;
        for (int k = 0; k < 5; k++) begin
            s_a = pick(w); s_b = pick(w); s_sel = 4'($urandom); s_m = 1'b0; s_vin = 1'b1;
            @(negedge clk);
            n_total++;
            if (o_vout !== 1'b1 || o_y !== ey || o_rin !== 1'b0)
                $display("FAIL bp_w%0d hold%0d: got vout=%b Y=%h rin=%b want vout=1 Y=%h rin=0", w, k, o_vout, o_y, o_rin, ey);
            else n_pass++;
        end
        s_vin = 1'b0;
        s_rout = 1'b1;
        @(posedge clk);
        #1 s_rout = 1'b0;
        @(negedge clk);
        n_total++; if (o_vout !== 1'b0) $display("FAIL bp_w%0d drop: got vout=%b want 0", w, o_vout); else n_pass++;
        n_total++; if (o_rin !== 1'b1) $display("FAIL bp_w%0d rin_after: got %b want 1", w, o_rin); else n_pass++;
    endtask

    task automatic test_abort(input int w, input int at_cnt);
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] ey;
        logic        seen;
        logic        rin_ok;
        logic        rel_ok;
        logic        z;
        logic [63:0] y;
        int          lat;
        cur_w = w;
        a = pick(w);
        b = ({$urandom, $urandom} & mask_of(w)) | 64'd1;
        @(negedge clk);
        s_a = a; s_b = b; s_sel = 4'b0101; s_m = 1'b1; s_vin = 1'b1;
        @(posedge clk);
        #1 s_vin = 1'b0;
        repeat (at_cnt) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 2 * w + 4; k++) begin
            if (o_vout) seen = 1'b1;
            @(negedge clk);
        end
        n_total++; if (seen !== 1'b0) $display("FAIL abort_w%0d vout_seen: got %b want 0", w, seen); else n_pass++;
        n_total++; if (o_rin !== 1'b1) $display("FAIL abort_w%0d idle: got rin=%b want 1", w, o_rin); else n_pass++;
        a = pick(w); b = pick(w);
        ey = ref_alu(w, a, b, 4'b0100, 1'b1);
        do_op(a, b, 4'b0100, 1'b1, rin_ok, lat, y, z, rel_ok);
        n_total++;
        if (y !== ey || lat != ref_lat(w, a, b, 4'b0100, 1'b1))
            $display("FAIL abort_w%0d next_op: got Y=%h lat=%0d want Y=%h lat=%0d", w, y, lat, ey, ref_lat(w, a, b, 4'b0100, 1'b1));
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1; s_a = '0; s_b = '0; s_sel = '0; s_m = 1'b0; s_vin = 1'b0; s_rout = 1'b0; cur_w = 32;
        test_reset();
        test_directed(32);
        test_backpressure(32);
        test_abort(32, 10);
        test_random(32, 150);
        test_directed(8);
        test_backpressure(8);
        test_abort(8, 5);
        test_random(8, 300);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alu_rv32m_iter.md
Name: alu_rv32m_iter

Overview:
- Parametrised, handshaked successor of the single-cycle RV32I ALU.
- Executes every base integer op with a registered 1-cycle result.
- Adds the RISC-V M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) on a shared iterative shift-add / restoring-divide datapath.
- Sits between operand read and writeback in the multi-cycle core; the control unit stalls on `ready_in`/`valid_out`.

Parameters:
- XLEN, 32: operand/result width; power of two, 8..64.
- SHW, $clog2(XLEN): derived localparam, not overridable; shift-amount width and iteration-counter width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- valid_in  input  1  operation request
- ready_in  output  1  block can accept; high only in IDLE and not in reset
- a  input  XLEN  operand rs1
- b  input  XLEN  operand rs2/imm
- sel  input  4  op select (see Behaviour)
- m  input  1  1 = M-extension op
- Y  output  XLEN  registered result
- zero  output  1  registered, Y==0
- valid_out  output  1  Y/zero valid
- ready_out  input  1  consumer takes result

Behaviour:
- Clocking and reset (already decided):
  - One clock `clk`; reset `rst` is synchronous and active-high.
  - Reset: state=IDLE, Y=0, zero=0, valid_out=0, counter=0; ready_in=0 while rst is high.
  - Reset mid-operation aborts the operation; the result is discarded and never presented.
- Handshake:
  - Accept on an edge with valid_in && ready_in; a, b, sel, m are latched at that edge.
  - Inputs are ignored outside acceptance.
  - valid_out, Y and zero are held stable until an edge with ready_out=1, then valid_out drops and state returns to IDLE.
  - No new accept in that same edge (throughput 1 op per 2 cycles minimum).
- FSM states:
  - IDLE: accept → CALC if m=1 and not a special case, else DONE.
  - CALC: counter counts 0..XLEN-1; at count XLEN-1 → DONE.
  - DONE: valid_out=1; on ready_out → IDLE.
- Base ops (m=0), sel[3:1]:
  - 000: add; sub when sel[0]=1.
  - 001: sll.
  - 010: slt, signed.
  - 011: sltu.
  - 100: xor.
  - 101: srl; sra when sel[0]=1.
  - 110: or.
  - 111: and.
  - Shift amount is b[SHW-1:0].
  - slt/sltu result is zero-extended to XLEN.
  - Latency: result and valid_out are visible in the cycle after the accept edge.
- M ops (m=1), sel[2:0] (RISC-V funct3); sel[3] is ignored:
  - 000: MUL, low XLEN bits of the product.
  - 001: MULH, s×s high.
  - 010: MULHSU, s×u high.
  - 011: MULHU, u×u high.
  - 100: DIV.
  - 101: DIVU.
  - 110: REM.
  - 111: REMU.
- M-op datapath:
  - Signed ops take magnitudes on acceptance and apply the sign correction in the final CALC cycle.
  - Multiply: 2·XLEN-bit accumulator, one bit of b per cycle.
  - Divide: restoring, one quotient bit per cycle.
  - Division rounds toward zero; the remainder takes the sign of the dividend.
  - Latency: valid_out rises after accept edge + XLEN edges (XLEN CALC cycles).
- Special cases resolved at accept, with 1-cycle latency like base ops:
  - b==0: DIV/DIVU → all ones; REM/REMU → a.
  - Signed overflow (a = most-negative, b = -1): DIV → a, REM → 0.
- Output flag:
  - zero is computed from the final Y and registered together with it.
- Arithmetic:
  - All arithmetic wraps modulo 2^XLEN; no overflow flag.
- Unsupported encodings: none; every {m, sel} combination is defined.

Test Plan:
- Reset, then add: rst high for 2 cycles → Y=0, valid_out=0, ready_in=0. Release; a=5, b=7, sel=0000, m=0 → next cycle valid_out=1, Y=12, zero=0.
- sub/sra/sltu: sub a=3, b=3 (sel=0001) → Y=0, zero=1. sra a=0x80000000, b=4 (sel=1011) → 0xF8000000. sltu a=1, b=0xFFFFFFFF (sel=0110) → 1.
- MULH latency: a=0xFFFFFFFF, b=2, m=1, sel=001 → valid_out exactly 32 edges after accept, Y=0xFFFFFFFF. MULHU with the same operands → Y=1.
- Division special cases:
  - DIV a=7, b=0 → Y=0xFFFFFFFF after 1 cycle.
  - REM a=0x80000000, b=0xFFFFFFFF → Y=0, zero=1.
  - DIV a=-7, b=2 → Y=-3 (0xFFFFFFFD).
  - REM a=-7, b=2 → Y=-1.
- Backpressure: ready_out=0 for 5 cycles after valid_out → Y held, ready_in=0, a new valid_in is not accepted. ready_out=1 → valid_out drops, ready_in=1 next cycle.
- Abort and width: rst pulsed at CALC count 10 of a DIVU → IDLE, valid_out never rises, next op correct. Rerun all scenarios with XLEN=8, where MUL latency = 8 edges.
